wb_load_stage: RTL and testbench

- Memory/writeback stage of the simple MIPS32 core; sits directly upstream of the register file write port (waddr/wdata/we).
- Accepts one retiring instruction per cycle from execute.
- ALU results are registered and written back after 1 cycle.
- Loads issue a word read over a req/ack data-memory handshake, extract and extend the byte/half/word, then write back; upstream is stalled while the read is outstanding.

---
 rtl/wb_load_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_wb_load_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_load_stage.sv
// wb_load_stage: memory/writeback stage of the simple MIPS32 core.
// ALU results are registered and written back one cycle after acceptance.
// Loads issue a word read over a req/ack handshake, then extract and
// extend the addressed byte/half/word (big-endian) before writeback.
// Upstream is stalled while a load read is outstanding.
//
// Optional build macro: WB_MISALIGN_EXC_EN
//   defined   -> misaligned LH/LHU/LW raise a one-cycle o_exc pulse,
//                issue no memory request and write no register.
//   undefined -> o_exc is constant 0; misaligned LH ignores ofs[0] and
//                LW ignores the whole offset.
module wb_load_stage #(
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic          i_rwe,
  input  logic [4:0]    i_dst,
  input  logic [31:0]   i_alu,
  input  logic          i_load,
  input  logic [2:0]    i_ltype,
  output logic          o_stall,
  output logic          o_mreq,
  output logic [AW-1:0] o_maddr,
  input  logic          i_mack,
  input  logic [31:0]   i_mrdata,
  output logic          o_we,
  output logic [4:0]    o_waddr,
  output logic [31:0]   o_wdata,
  output logic          o_exc
);

  // Load type encodings (opcode[2:0]); anything else behaves as LW.
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MREQ = 1'b1
  } state_t;

  // Select and extend the addressed field of a big-endian memory word.
  function automatic logic [31:0] extract_load(
    input logic [31:0] word,
    input logic [2:0]  ltype,
    input logic [1:0]  ofs
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (ofs)
      2'd0:    byte_v = word[31:24];
      2'd1:    byte_v = word[23:16];
      2'd2:    byte_v = word[15:8];
      2'd3:    byte_v = word[7:0];
      default: byte_v = word[7:0];
    endcase
    if (ofs[1]) begin
      half_v = word[15:0];
    end else begin
      half_v = word[31:16];
    end
    case (ltype)
      LT_LB:   res_v = {{24{byte_v[7]}}, byte_v};
      LT_LH:   res_v = {{16{half_v[15]}}, half_v};
      LT_LBU:  res_v = {24'h00_0000, byte_v};
      LT_LHU:  res_v = {16'h0000, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

`ifdef WB_MISALIGN_EXC_EN
  // True when the access width does not fit the offset inside the word.
  function automatic logic is_misaligned(
    input logic [2:0] ltype,
    input logic [1:0] ofs
  );
    logic mis_v;
    case (ltype)
      LT_LB, LT_LBU: mis_v = 1'b0;
      LT_LH, LT_LHU: mis_v = ofs[0];
      default:       mis_v = (ofs != 2'b00);
    endcase
    return mis_v;
  endfunction
`endif

  state_t        state_r, state_s;
  logic          we_r, we_s;
  logic [4:0]    waddr_r, waddr_s;
  logic [31:0]   wdata_r, wdata_s;
  logic          mreq_r, mreq_s;
  logic [AW-1:0] maddr_r, maddr_s;
  logic [4:0]    ldst_r, ldst_s;
  logic          lrwe_r, lrwe_s;
  logic [2:0]    ltype_r, ltype_s;
  logic [1:0]    lofs_r, lofs_s;
`ifdef WB_MISALIGN_EXC_EN
  logic          exc_r, exc_s;
`endif

  // Next-state and next-output logic for the IDLE/MREQ controller.
  always_comb begin
    state_s = state_r;
    we_s    = 1'b0;
    waddr_s = waddr_r;
    wdata_s = wdata_r;
    mreq_s  = mreq_r;
    maddr_s = maddr_r;
    ldst_s  = ldst_r;
    lrwe_s  = lrwe_r;
    ltype_s = ltype_r;
    lofs_s  = lofs_r;
`ifdef WB_MISALIGN_EXC_EN
    exc_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          if (i_load) begin
`ifdef WB_MISALIGN_EXC_EN
            if (is_misaligned(i_ltype, i_alu[1:0])) begin
              exc_s = 1'b1;
            end else begin
              ldst_s  = i_dst;
              lrwe_s  = i_rwe;
              ltype_s = i_ltype;
              lofs_s  = i_alu[1:0];
              maddr_s = {i_alu[AW-1:2], 2'b00};
              mreq_s  = 1'b1;
              state_s = ST_MREQ;
            end
`else
            ldst_s  = i_dst;
            lrwe_s  = i_rwe;
            ltype_s = i_ltype;
            lofs_s  = i_alu[1:0];
            maddr_s = {i_alu[AW-1:2], 2'b00};
            mreq_s  = 1'b1;
            state_s = ST_MREQ;
`endif
          end else begin
            // r0 is hardwired, so a write to it is dropped.
            we_s    = i_rwe && (i_dst != 5'd0);
            waddr_s = i_dst;
            wdata_s = i_alu;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MREQ: begin
        // Request and address stay stable until the ack is seen.
        if (i_mack) begin
          we_s    = lrwe_r && (ldst_r != 5'd0);
          waddr_s = ldst_r;
          wdata_s = extract_load(i_mrdata, ltype_r, lofs_r);
          mreq_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_MREQ;
        end
      end
      default: begin
        mreq_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      we_r    <= 1'b0;
      waddr_r <= 5'd0;
      wdata_r <= 32'd0;
      mreq_r  <= 1'b0;
      maddr_r <= '0;
      ldst_r  <= 5'd0;
      lrwe_r  <= 1'b0;
      ltype_r <= 3'd0;
      lofs_r  <= 2'd0;
`ifdef WB_MISALIGN_EXC_EN
      exc_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      we_r    <= we_s;
      waddr_r <= waddr_s;
      wdata_r <= wdata_s;
      mreq_r  <= mreq_s;
      maddr_r <= maddr_s;
      ldst_r  <= ldst_s;
      lrwe_r  <= lrwe_s;
      ltype_r <= ltype_s;
      lofs_r  <= lofs_s;
`ifdef WB_MISALIGN_EXC_EN
      exc_r   <= exc_s;
`endif
    end
  end

  assign o_stall = (state_r == ST_MREQ);
  assign o_mreq  = mreq_r;
  assign o_maddr = maddr_r;
  assign o_we    = we_r;
  assign o_waddr = waddr_r;
  assign o_wdata = wdata_r;
`ifdef WB_MISALIGN_EXC_EN
  assign o_exc   = exc_r;
`else
  assign o_exc   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_load_stage.sv
// Directed self-checking bench for wb_load_stage. Inputs are driven on
// the falling edge and outputs are checked on the following falling edge.
module tb_wb_load_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        i_rwe;
  logic [4:0]  i_dst;
  logic [31:0] i_alu;
  logic        i_load;
  logic [2:0]  i_ltype;
  logic        o_stall;
  logic        o_mreq;
  logic [31:0] o_maddr;
  logic        i_mack;
  logic [31:0] i_mrdata;
  logic        o_we;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic        o_exc;

  int compared   = 0;
  int mismatched = 0;

  wb_load_stage #(.AW(32)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_rwe    (i_rwe),
    .i_dst    (i_dst),
    .i_alu    (i_alu),
    .i_load   (i_load),
    .i_ltype  (i_ltype),
    .o_stall  (o_stall),
    .o_mreq   (o_mreq),
    .o_maddr  (o_maddr),
    .i_mack   (i_mack),
    .i_mrdata (i_mrdata),
    .o_we     (o_we),
    .o_waddr  (o_waddr),
    .o_wdata  (o_wdata),
    .o_exc    (o_exc)
  );

  // Free-running clock, 10 time-unit period.
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One load: present it, hold ack low for 'waits' cycles, then ack.
  task automatic run_load(input string tag, input logic [4:0] dst, input logic [31:0] addr,
                          input logic [2:0] lt, input logic [31:0] data, input int waits,
                          input logic [31:0] exp_maddr, input logic exp_we,
                          input logic [31:0] exp_wdata);
    int stall_cnt;
    @(negedge i_clk);
    i_valid = 1'b1; i_load = 1'b1; i_rwe = 1'b1; i_dst = dst; i_alu = addr; i_ltype = lt;
    @(negedge i_clk);
    i_valid = 1'b0; i_load = 1'b0;
    chk({tag, "_mreq"}, {31'd0, o_mreq}, 32'd1);
    chk({tag, "_maddr"}, o_maddr, exp_maddr);
    chk({tag, "_we_req"}, {31'd0, o_we}, 32'd0);
    stall_cnt = (o_stall === 1'b1) ? 1 : 0;
    for (int i = 0; i < waits; i++) begin
      @(negedge i_clk);
      if (o_stall === 1'b1) stall_cnt++;
      chk({tag, "_maddr_hold"}, o_maddr, exp_maddr);
    end
    chk({tag, "_stall_cycles"}, stall_cnt, waits + 1);
    i_mack = 1'b1; i_mrdata = data;
    @(negedge i_clk);
    i_mack = 1'b0;
    chk({tag, "_stall_done"}, {31'd0, o_stall}, 32'd0);
    chk({tag, "_mreq_done"}, {31'd0, o_mreq}, 32'd0);
    chk({tag, "_we"}, {31'd0, o_we}, {31'd0, exp_we});
    if (exp_we) begin
      chk({tag, "_waddr"}, {27'd0, o_waddr}, {27'd0, dst});
      chk({tag, "_wdata"}, o_wdata, exp_wdata);
    end else begin
      chk({tag, "_no_exc"}, {31'd0, o_exc}, 32'd0);
    end
    @(negedge i_clk);
    chk({tag, "_we_pulse"}, {31'd0, o_we}, 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_rwe = 1'b0; i_dst = 5'd0; i_alu = 32'd0;
    i_load = 1'b0; i_ltype = 3'd0; i_mack = 1'b0; i_mrdata = 32'd0;

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_we", {31'd0, o_we}, 32'd0);
    chk("rst_waddr", {27'd0, o_waddr}, 32'd0);
    chk("rst_wdata", o_wdata, 32'd0);
    chk("rst_mreq", {31'd0, o_mreq}, 32'd0);
    chk("rst_maddr", o_maddr, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_exc", {31'd0, o_exc}, 32'd0);
    i_rst = 1'b0;

    // Back-to-back ALU ops: dst 5, 6, 0
    @(negedge i_clk);
    i_valid = 1'b1; i_rwe = 1'b1; i_dst = 5'd5; i_alu = 32'h0000_0011;
    @(negedge i_clk);
    chk("alu1_we", {31'd0, o_we}, 32'd1);
    chk("alu1_waddr", {27'd0, o_waddr}, 32'd5);
    chk("alu1_wdata", o_wdata, 32'h0000_0011);
    chk("alu1_stall", {31'd0, o_stall}, 32'd0);
    i_dst = 5'd6; i_alu = 32'h0000_0022;
    @(negedge i_clk);
    chk("alu2_we", {31'd0, o_we}, 32'd1);
    chk("alu2_waddr", {27'd0, o_waddr}, 32'd6);
    chk("alu2_wdata", o_wdata, 32'h0000_0022);
    chk("alu2_stall", {31'd0, o_stall}, 32'd0);
    i_dst = 5'd0; i_alu = 32'h0000_0033;
    @(negedge i_clk);
    chk("alu3_we_r0", {31'd0, o_we}, 32'd0);
    chk("alu3_stall", {31'd0, o_stall}, 32'd0);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("alu_idle_we", {31'd0, o_we}, 32'd0);

    // Ack while idle is ignored
    i_mack = 1'b1; i_mrdata = 32'hFFFF_FFFF;
    @(negedge i_clk);
    i_mack = 1'b0;
    chk("idle_ack_we", {31'd0, o_we}, 32'd0);
    chk("idle_ack_mreq", {31'd0, o_mreq}, 32'd0);

    // Loads with hand-computed extraction
    run_load("lb",   5'd9,  32'h0000_1003, 3'b000, 32'h1234_5680, 3, 32'h0000_1000, 1'b1, 32'hFFFF_FF80);
    run_load("lbu",  5'd9,  32'h0000_1003, 3'b100, 32'h1234_5680, 1, 32'h0000_1000, 1'b1, 32'h0000_0080);
    run_load("lb1",  5'd3,  32'h0000_1001, 3'b000, 32'h12AB_3456, 0, 32'h0000_1000, 1'b1, 32'hFFFF_FFAB);
    run_load("lbu0", 5'd4,  32'h0000_1000, 3'b100, 32'h7F00_0000, 2, 32'h0000_1000, 1'b1, 32'h0000_007F);
    run_load("lh",   5'd11, 32'h0000_1002, 3'b001, 32'h0000_8001, 2, 32'h0000_1000, 1'b1, 32'hFFFF_8001);
    run_load("lhu",  5'd12, 32'h0000_1000, 3'b101, 32'h8001_0000, 1, 32'h0000_1000, 1'b1, 32'h0000_8001);
    run_load("lw",   5'd13, 32'h0000_3004, 3'b011, 32'hDEAD_BEEF, 1, 32'h0000_3004, 1'b1, 32'hDEAD_BEEF);
    run_load("lw_r0", 5'd0, 32'h0000_3000, 3'b011, 32'h1111_2222, 0, 32'h0000_3000, 1'b0, 32'h0000_0000);

    // Misaligned LW at 0x2002
`ifdef WB_MISALIGN_EXC_EN
    @(negedge i_clk);
    i_valid = 1'b1; i_load = 1'b1; i_rwe = 1'b1; i_dst = 5'd14; i_alu = 32'h0000_2002; i_ltype = 3'b011;
    @(negedge i_clk);
    i_valid = 1'b0; i_load = 1'b0;
    chk("mis_mreq", {31'd0, o_mreq}, 32'd0);
    chk("mis_exc", {31'd0, o_exc}, 32'd1);
    chk("mis_we", {31'd0, o_we}, 32'd0);
    chk("mis_stall", {31'd0, o_stall}, 32'd0);
    @(negedge i_clk);
    chk("mis_exc_pulse", {31'd0, o_exc}, 32'd0);
`else
    run_load("lw_mis", 5'd14, 32'h0000_2002, 3'b011, 32'hA5A5_5A5A, 1, 32'h0000_2000, 1'b1, 32'hA5A5_5A5A);
    chk("mis_exc_tied", {31'd0, o_exc}, 32'd0);
`endif

    // Load followed immediately by an ALU op held by the stall
    @(negedge i_clk);
    i_valid = 1'b1; i_load = 1'b1; i_rwe = 1'b1; i_dst = 5'd10; i_alu = 32'h0000_1000; i_ltype = 3'b011;
    @(negedge i_clk);
    chk("ld_alu_mreq", {31'd0, o_mreq}, 32'd1);
    i_load = 1'b0; i_dst = 5'd7; i_alu = 32'h0000_0055;
    @(negedge i_clk);
    chk("ld_alu_stall", {31'd0, o_stall}, 32'd1);
    chk("ld_alu_we_wait", {31'd0, o_we}, 32'd0);
    i_mack = 1'b1; i_mrdata = 32'hCAFE_F00D;
    @(negedge i_clk);
    i_mack = 1'b0;
    chk("ld_alu_ld_we", {31'd0, o_we}, 32'd1);
    chk("ld_alu_ld_waddr", {27'd0, o_waddr}, 32'd10);
    chk("ld_alu_ld_wdata", o_wdata, 32'hCAFE_F00D);
    chk("ld_alu_stall_rel", {31'd0, o_stall}, 32'd0);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("ld_alu_alu_we", {31'd0, o_we}, 32'd1);
    chk("ld_alu_alu_waddr", {27'd0, o_waddr}, 32'd7);
    chk("ld_alu_alu_wdata", o_wdata, 32'h0000_0055);
    @(negedge i_clk);
    chk("ld_alu_we_end", {31'd0, o_we}, 32'd0);

    // Reset mid-stream during an outstanding load; late ack ignored
    i_valid = 1'b1; i_load = 1'b1; i_rwe = 1'b1; i_dst = 5'd15; i_alu = 32'h0000_4000; i_ltype = 3'b011;
    @(negedge i_clk);
    i_valid = 1'b0; i_load = 1'b0;
    chk("rstm_mreq_before", {31'd0, o_mreq}, 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rstm_mreq", {31'd0, o_mreq}, 32'd0);
    chk("rstm_we", {31'd0, o_we}, 32'd0);
    chk("rstm_stall", {31'd0, o_stall}, 32'd0);
    chk("rstm_maddr", o_maddr, 32'd0);
    i_mack = 1'b1; i_mrdata = 32'h1357_9BDF;
    @(negedge i_clk);
    i_mack = 1'b0;
    chk("rstm_late_ack_we", {31'd0, o_we}, 32'd0);
    chk("rstm_late_ack_stall", {31'd0, o_stall}, 32'd0);
    @(negedge i_clk);
    chk("rstm_quiet_we", {31'd0, o_we}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
